// File: rtl/mbr_mem_seq.sv
// Memory buffer register with a small RAM-access sequencer for the accumulator CPU.
// Handles one CU command per handshake: load from a datapath channel, RAM read, or RAM write.
module mbr_mem_seq #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NSRC     = 4,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [3:0]             cmd_src,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [NSRC*DATA_W-1:0] src_data,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [DATA_W-1:0]      mbr_q,
    output logic [DATA_W/2-1:0]    mbr_lo,
    output logic [DATA_W/2-1:0]    mbr_hi,
    output logic                   done,
    output logic                   err
);

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;
    localparam logic [1:0] OpNop   = 2'b11;

    localparam logic [3:0] WaitCnt = 4'(WAIT_CYC);

    if (DATA_W < 8 || (DATA_W % 2) != 0) begin : g_bad_data_w
        $error("mbr_mem_seq: DATA_W must be even and at least 8");
    end
    if (NSRC < 1 || NSRC > 16) begin : g_bad_nsrc
        $error("mbr_mem_seq: NSRC must be in 1..16");
    end
    if (WAIT_CYC > 15) begin : g_bad_wait
        $error("mbr_mem_seq: WAIT_CYC must be in 0..15");
    end

    typedef enum logic [0:0] {StIdle, StMem} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mbr_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [DATA_W-1:0]   src_sel;
    logic                src_ok;

    // Ready is forced low during reset so no command can slip in on a reset edge.
    assign cmd_ready = (state_q == StIdle) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // Channel mux; out-of-range indices leave src_ok low and never index src_data.
    always_comb begin
        src_sel = '0;
        src_ok  = 1'b0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (cmd_src == 4'(k)) begin
                src_sel = src_data[k*DATA_W +: DATA_W];
                src_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mbr_d       = mbr_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (cmd_op)
                        OpLoad: begin
                            done_d = 1'b1;
                            if (src_ok) begin
                                mbr_d = src_sel;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OpRead, OpWrite: begin
                            mem_addr_d  = cmd_addr;
                            mem_wdata_d = mbr_q;
                            cnt_d       = WaitCnt;
                            mem_en_d    = 1'b1;
                            mem_we_d    = (cmd_op == OpWrite);
                            state_d     = StMem;
                        end
                        OpNop: begin
                            done_d = 1'b1;
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            StMem: begin
                if (cnt_q == 4'd0) begin
                    // mem_we_q still tells read from write in the final cycle.
                    if (!mem_we_q) begin
                        mbr_d = mem_rdata;
                    end
                    state_d  = StIdle;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mbr_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mbr_q       <= mbr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mbr_lo    = mbr_q[DATA_W/2-1:0];
    assign mbr_hi    = mbr_q[DATA_W-1:DATA_W/2];

endmodule
